// File: rtl/trace_arbiter.sv
// Round-robin arbiter that serializes GRF/DM write-trace messages into ASCII, one char per cycle.
// Optional macro TRACE_ALIGN_CHECK_EN drops misaligned requests (ack + err pulse, no chars).
module trace_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        grf_req,
  input  logic [15:0] grf_time,
  input  logic [31:0] grf_pc,
  input  logic [4:0]  grf_reg,
  input  logic [31:0] grf_data,
  input  logic        dm_req,
  input  logic [15:0] dm_time,
  input  logic [31:0] dm_pc,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_data,
  output logic        grf_ack,
  output logic        dm_ack,
  output logic [7:0]  char,
  output logic        char_valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, EMIT, LAST} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;          // 1: dm has priority on a tie
  logic        sel_q, sel_d;          // 1: latched message is DM
  logic [5:0]  idx_q, idx_d;
  logic [2:0]  tlen_q, tlen_d;
  logic [3:0]  alen_q, alen_d;
  logic [15:0] time_q, time_d;
  logic [31:0] pc_q, pc_d, arg_q, arg_d, data_q, data_d;
  logic        grf_ack_q, grf_ack_d, dm_ack_q, dm_ack_d, err_q, err_d;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h57 + {4'b0, n});
  endfunction

  // Grant selection; an acked requester is masked while its ack is still visible.
  logic req_g, req_m, gnt_grf, gnt_dm, misalign;
  assign req_g   = grf_req & ~grf_ack_q;
  assign req_m   = dm_req & ~dm_ack_q;
  assign gnt_grf = req_g & (~req_m | ~ptr_q);
  assign gnt_dm  = req_m & ~gnt_grf;

`ifdef TRACE_ALIGN_CHECK_EN
  assign misalign = gnt_grf ? (grf_pc[1:0] != 2'b00)
                            : ((dm_pc[1:0] != 2'b00) || (dm_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Time is stored left-aligned so its first significant digit sits in the top nibble.
  logic [15:0] t_in, t_al;
  logic [2:0]  t_len;
  always_comb begin
    t_in = gnt_dm ? dm_time : grf_time;
    if (t_in[15:12] != 4'd0) begin
      t_len = 3'd4; t_al = t_in;
    end else if (t_in[11:8] != 4'd0) begin
      t_len = 3'd3; t_al = {t_in[11:0], 4'b0};
    end else if (t_in[7:4] != 4'd0) begin
      t_len = 3'd2; t_al = {t_in[7:0], 8'b0};
    end else begin
      t_len = 3'd1; t_al = {t_in[3:0], 12'b0};
    end
  end

  logic [1:0] tens;
  logic [4:0] ones;
  always_comb begin
    if (grf_reg >= 5'd30) begin
      tens = 2'd3; ones = grf_reg - 5'd30;
    end else if (grf_reg >= 5'd20) begin
      tens = 2'd2; ones = grf_reg - 5'd20;
    end else if (grf_reg >= 5'd10) begin
      tens = 2'd1; ones = grf_reg - 5'd10;
    end else begin
      tens = 2'd0; ones = grf_reg;
    end
  end

  // Field boundaries within the message, derived from the latched lengths.
  logic [5:0] p_at, p_colon, p_sp, p_tag, p_arg, p_arrow, p_data, p_hash;
  assign p_at    = 6'd1 + {3'b0, tlen_q};
  assign p_colon = p_at + 6'd9;
  assign p_sp    = p_colon + 6'd1;
  assign p_tag   = p_sp + 6'd1;
  assign p_arg   = p_tag + 6'd1;
  assign p_arrow = p_arg + {2'b0, alen_q};
  assign p_data  = p_arrow + 6'd4;
  assign p_hash  = p_data + 6'd8;

  logic [7:0] ch;
  logic [5:0] arrow_off;
  assign arrow_off = idx_q - p_arrow;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    tlen_d    = tlen_q;
    alen_d    = alen_q;
    time_d    = time_q;
    pc_d      = pc_q;
    arg_d     = arg_q;
    data_d    = data_q;
    grf_ack_d = 1'b0;
    dm_ack_d  = 1'b0;
    err_d     = 1'b0;
    ch        = 8'h00;

    unique case (state_q)
      IDLE: begin
        if (gnt_grf || gnt_dm) begin
          grf_ack_d = gnt_grf;
          dm_ack_d  = gnt_dm;
          ptr_d     = gnt_grf;
          sel_d     = gnt_dm;
          idx_d     = '0;
          tlen_d    = t_len;
          time_d    = t_al;
          if (gnt_dm) begin
            pc_d   = dm_pc;
            arg_d  = dm_addr;
            alen_d = 4'd8;
            data_d = dm_data;
          end else begin
            pc_d   = grf_pc;
            data_d = grf_data;
            if (tens != 2'd0) begin
              arg_d  = {2'b0, tens, ones[3:0], 24'b0};
              alen_d = 4'd2;
            end else begin
              arg_d  = {ones[3:0], 28'b0};
              alen_d = 4'd1;
            end
          end
          if (misalign) err_d = 1'b1;
          else          state_d = EMIT;
        end
      end
      EMIT: begin
        idx_d = idx_q + 6'd1;
        if (idx_d == p_hash) state_d = LAST;
        if (idx_q == 6'd0) begin
          ch = 8'h5e;
        end else if (idx_q < p_at) begin
          ch = hex(time_q[15:12]);
          time_d = {time_q[11:0], 4'b0};
        end else if (idx_q == p_at) begin
          ch = 8'h40;
        end else if (idx_q < p_colon) begin
          ch = hex(pc_q[31:28]);
          pc_d = {pc_q[27:0], 4'b0};
        end else if (idx_q == p_colon) begin
          ch = 8'h3a;
        end else if (idx_q == p_sp) begin
          ch = 8'h20;
        end else if (idx_q == p_tag) begin
          ch = sel_q ? 8'h2a : 8'h24;
        end else if (idx_q < p_arrow) begin
          ch = hex(arg_q[31:28]);
          arg_d = {arg_q[27:0], 4'b0};
        end else if (idx_q < p_data) begin
          unique case (arrow_off[1:0])
            2'd1:    ch = 8'h3c;
            2'd2:    ch = 8'h3d;
            default: ch = 8'h20;
          endcase
        end else begin
          ch = hex(data_q[31:28]);
          data_d = {data_q[27:0], 4'b0};
        end
      end
      LAST: begin
        ch      = 8'h23;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      sel_q     <= 1'b0;
      idx_q     <= '0;
      tlen_q    <= '0;
      alen_q    <= '0;
      time_q    <= '0;
      pc_q      <= '0;
      arg_q     <= '0;
      data_q    <= '0;
      grf_ack_q <= 1'b0;
      dm_ack_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      tlen_q    <= tlen_d;
      alen_q    <= alen_d;
      time_q    <= time_d;
      pc_q      <= pc_d;
      arg_q     <= arg_d;
      data_q    <= data_d;
      grf_ack_q <= grf_ack_d;
      dm_ack_q  <= dm_ack_d;
      err_q     <= err_d;
    end
  end

  assign char_valid = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign char       = ch;
  assign grf_ack    = grf_ack_q;
  assign dm_ack     = dm_ack_q;
  assign err        = err_q;

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed bench for trace_arbiter: message text, arbitration order, reset abort, alignment drop.
module tb_trace_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        grf_req = 1'b0, dm_req = 1'b0;
  logic [15:0] grf_time = '0, dm_time = '0;
  logic [31:0] grf_pc = '0, grf_data = '0, dm_pc = '0, dm_addr = '0, dm_data = '0;
  logic [4:0]  grf_reg = '0;
  logic        grf_ack, dm_ack, char_valid, busy, err;
  logic [7:0]  chr;

  int total = 0;
  int bad = 0;

  trace_arbiter dut (
    .clk(clk), .reset(reset),
    .grf_req(grf_req), .grf_time(grf_time), .grf_pc(grf_pc), .grf_reg(grf_reg), .grf_data(grf_data),
    .dm_req(dm_req), .dm_time(dm_time), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_data(dm_data),
    .grf_ack(grf_ack), .dm_ack(dm_ack), .char(chr), .char_valid(char_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic set_grf(input logic [15:0] t, input logic [31:0] pc, input logic [4:0] r, input logic [31:0] d);
    grf_time = t; grf_pc = pc; grf_reg = r; grf_data = d;
  endtask

  task automatic set_dm(input logic [15:0] t, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
    dm_time = t; dm_pc = pc; dm_addr = a; dm_data = d;
  endtask

  // Captures one message; the requester drops its request and scrambles its fields on ack.
  task automatic run_msg(input int budget, output string s, output int nvalid, output int ngack,
                         output int ndack, output int nerr, output int first, output int nbad);
    bit started = 0;
    s = ""; nvalid = 0; ngack = 0; ndack = 0; nerr = 0; first = 0; nbad = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (grf_ack) begin
        ngack++; grf_req = 0;
        grf_time = 16'h4321; grf_pc = ~grf_pc; grf_reg = ~grf_reg; grf_data = ~grf_data;
      end
      if (dm_ack) begin
        ndack++; dm_req = 0;
        dm_time = 16'h8765; dm_pc = ~dm_pc; dm_addr = ~dm_addr; dm_data = ~dm_data;
      end
      if (err) nerr++;
      if (busy !== char_valid) nbad++;
      if (char_valid) begin
        if (!started) first = i;
        started = 1;
        nvalid++;
        s = {s, $sformatf("%c", chr)};
      end else begin
        if (chr !== 8'h00) nbad++;
        if (started) break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", char_valid); end
    total++; if (chr !== 8'h00) begin bad++; $display("FAIL rst_char got=%h want=00", chr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if ({grf_ack, dm_ack} !== 2'b00) begin bad++; $display("FAIL rst_ack got=%b want=00", {grf_ack, dm_ack}); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    reset = 0;
  endtask

  task automatic test_grf_msg;
    string s; int nv, ng, nd, ne, f, nb;
    set_grf(16'h0012, 32'h00003000, 5'd5, 32'h0000abcd);
    grf_req = 1;
    run_msg(60, s, nv, ng, nd, ne, f, nb);
    total++; if (s != "^12@00003000: $5 <= 0000abcd#") begin bad++; $display("FAIL grf_msg got=\"%s\" want=\"^12@00003000: $5 <= 0000abcd#\"", s); end
    total++; if (nv !== 29) begin bad++; $display("FAIL grf_len got=%0d want=29", nv); end
    total++; if (ng !== 1 || nd !== 0) begin bad++; $display("FAIL grf_acks got=%0d/%0d want=1/0", ng, nd); end
    total++; if (f !== 1) begin bad++; $display("FAIL grf_latency got=%0d want=1", f); end
    total++; if (nb !== 0 || ne !== 0) begin bad++; $display("FAIL grf_idle_busy_err got=%0d/%0d want=0/0", nb, ne); end
  endtask

  task automatic test_dm_msg;
    string s; int nv, ng, nd, ne, f, nb;
    set_dm(16'h0007, 32'h00003004, 32'h00000010, 32'hffffffff);
    dm_req = 1;
    run_msg(60, s, nv, ng, nd, ne, f, nb);
    total++; if (s != "^7@00003004: *00000010 <= ffffffff#") begin bad++; $display("FAIL dm_msg got=\"%s\" want=\"^7@00003004: *00000010 <= ffffffff#\"", s); end
    total++; if (nv !== 35) begin bad++; $display("FAIL dm_len got=%0d want=35", nv); end
    total++; if (nd !== 1 || ng !== 0) begin bad++; $display("FAIL dm_acks got=%0d/%0d want=1/0", nd, ng); end
  endtask

  task automatic test_bcd_bounds;
    string s; int nv, ng, nd, ne, f, nb;
    set_grf(16'h0000, 32'h00001234, 5'd31, 32'h00000001);
    grf_req = 1;
    run_msg(60, s, nv, ng, nd, ne, f, nb);
    total++; if (s != "^0@00001234: $31 <= 00000001#") begin bad++; $display("FAIL bcd_zero got=\"%s\" want=\"^0@00001234: $31 <= 00000001#\"", s); end
    set_dm(16'h9999, 32'h0000abc0, 32'h00000100, 32'hdeadbeef);
    dm_req = 1;
    run_msg(60, s, nv, ng, nd, ne, f, nb);
    total++; if (s != "^9999@0000abc0: *00000100 <= deadbeef#") begin bad++; $display("FAIL bcd_9999 got=\"%s\" want=\"^9999@0000abc0: *00000100 <= deadbeef#\"", s); end
    total++; if (nv !== 38) begin bad++; $display("FAIL bcd_9999_len got=%0d want=38", nv); end
  endtask

  task automatic test_round_robin;
    string s; int nv, ng, nd, ne, f, nb;
    string eg, ed;
    eg = "^300@00000040: $10 <= 0000000a#";
    ed = "^1@00000044: *00000008 <= 00000000#";
    @(negedge clk);
    reset = 1;
    set_grf(16'h0300, 32'h00000040, 5'd10, 32'h0000000a);
    set_dm(16'h0001, 32'h00000044, 32'h00000008, 32'h00000000);
    grf_req = 1; dm_req = 1;
    @(negedge clk);
    reset = 0;
    run_msg(60, s, nv, ng, nd, ne, f, nb);
    total++; if (s != eg || f !== 1) begin bad++; $display("FAIL rr_first got=\"%s\"@%0d want=\"%s\"@1", s, f, eg); end
    run_msg(60, s, nv, ng, nd, ne, f, nb);
    total++; if (s != ed || f !== 1) begin bad++; $display("FAIL rr_second got=\"%s\"@%0d want=\"%s\"@1", s, f, ed); end
    // Two lone grf messages; the second runs with the pointer favouring dm.
    for (int k = 0; k < 2; k++) begin
      set_grf(16'h0300, 32'h00000040, 5'd10, 32'h0000000a);
      grf_req = 1;
      run_msg(60, s, nv, ng, nd, ne, f, nb);
      total++; if (s != eg || ng !== 1) begin bad++; $display("FAIL rr_single%0d got=\"%s\" acks=%0d want=\"%s\" acks=1", k, s, ng, eg); end
    end
    set_grf(16'h0300, 32'h00000040, 5'd10, 32'h0000000a);
    set_dm(16'h0001, 32'h00000044, 32'h00000008, 32'h00000000);
    grf_req = 1; dm_req = 1;
    run_msg(60, s, nv, ng, nd, ne, f, nb);
    total++; if (s != ed) begin bad++; $display("FAIL rr_dm_wins got=\"%s\" want=\"%s\"", s, ed); end
    total++; if (ng !== 0) begin bad++; $display("FAIL rr_pending_noack got=%0d want=0", ng); end
    run_msg(60, s, nv, ng, nd, ne, f, nb);
    total++; if (s != eg || f !== 1) begin bad++; $display("FAIL rr_grf_after got=\"%s\"@%0d want=\"%s\"@1", s, f, eg); end
  endtask

  task automatic test_reset_mid;
    string s; int nv, ng, nd, ne, f, nb;
    int cnt = 0;
    set_grf(16'h0012, 32'h00003000, 5'd5, 32'h0000abcd);
    grf_req = 1;
    for (int i = 0; i < 40 && cnt < 10; i++) begin
      @(negedge clk);
      if (char_valid) cnt++;
    end
    reset = 1;
    grf_req = 1;
    #1;
    total++; if (char_valid !== 1'b0 || chr !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL midrst_abort got=%b/%h/%b want=0/00/0", char_valid, chr, busy); end
    total++; if (cnt !== 10) begin bad++; $display("FAIL midrst_reach got=%0d want=10", cnt); end
    @(negedge clk);
    reset = 0;
    run_msg(60, s, nv, ng, nd, ne, f, nb);
    total++; if (s != "^12@00003000: $5 <= 0000abcd#" || f !== 1) begin bad++; $display("FAIL midrst_resume got=\"%s\"@%0d want=\"^12@00003000: $5 <= 0000abcd#\"@1", s, f); end
  endtask

  task automatic test_align;
    string s; int nv, ng, nd, ne, f, nb;
    set_dm(16'h0105, 32'h00003008, 32'h00000002, 32'h12345678);
    dm_req = 1;
`ifdef TRACE_ALIGN_CHECK_EN
    run_msg(8, s, nv, ng, nd, ne, f, nb);
    total++; if (nd !== 1 || ne !== 1) begin bad++; $display("FAIL align_drop ack/err got=%0d/%0d want=1/1", nd, ne); end
    total++; if (nv !== 0) begin bad++; $display("FAIL align_nochars got=%0d want=0", nv); end
`else
    run_msg(60, s, nv, ng, nd, ne, f, nb);
    total++; if (s != "^105@00003008: *00000002 <= 12345678#") begin bad++; $display("FAIL align_pass got=\"%s\" want=\"^105@00003008: *00000002 <= 12345678#\"", s); end
    total++; if (ne !== 0 || nd !== 1) begin bad++; $display("FAIL align_err got=%0d ack=%0d want=0 ack=1", ne, nd); end
`endif
    set_grf(16'h0012, 32'h00003000, 5'd5, 32'h0000abcd);
    grf_req = 1;
    run_msg(60, s, nv, ng, nd, ne, f, nb);
    total++; if (s != "^12@00003000: $5 <= 0000abcd#") begin bad++; $display("FAIL align_after got=\"%s\" want=\"^12@00003000: $5 <= 0000abcd#\"", s); end
  endtask

  initial begin
    test_reset;
    test_grf_msg;
    test_dm_msg;
    test_bcd_bounds;
    test_round_robin;
    test_reset_mid;
    test_align;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
